// File: rtl/vga_overlay_pkg.sv
// Shared encodings and constants for the on-screen register panel.
package vga_overlay_pkg;

    localparam logic [1:0] V_IDLE = 2'd0;
    localparam logic [1:0] V_ROW  = 2'd1;
    localparam logic [1:0] V_GAP  = 2'd2;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;

    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 480;

endpackage

// File: rtl/vga_row_timer.sv
// Vertical schedule: walks rows and inter-row gaps, one step per line (vga_h == 0).
module vga_row_timer
    import vga_overlay_pkg::*;
#(
    parameter int          NUM_REGS  = 7,
    parameter logic [10:0] START_V   = 11'd10,
    parameter int          ROW_H     = 20,
    parameter int          ROW_PITCH = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] vga_h,
    input  logic [10:0] vga_v,
    output logic [2:0]  row,
    output logic        row_visible
);
    localparam int LW = $clog2(ROW_PITCH);

    logic [1:0]    state_q;
    logic [2:0]    row_q;
    logic [LW-1:0] line_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= V_IDLE;
            row_q   <= '0;
            line_q  <= '0;
        end else if (vga_h == '0) begin
            case (state_q)
                V_IDLE: begin
                    if (vga_v == START_V) begin
                        state_q <= V_ROW;
                        row_q   <= '0;
                        line_q  <= '0;
                    end
                end
                V_ROW: begin
                    if (vga_v == '0) begin
                        state_q <= V_IDLE;
                        row_q   <= '0;
                        line_q  <= '0;
                    end else begin
                        line_q <= line_q + 1'b1;
                        if (line_q == LW'(ROW_H - 1)) state_q <= V_GAP;
                    end
                end
                V_GAP: begin
                    if (vga_v == '0) begin
                        state_q <= V_IDLE;
                        row_q   <= '0;
                        line_q  <= '0;
                    end else if (line_q == LW'(ROW_PITCH - 1)) begin
                        line_q <= '0;
                        // Last row done: park the row index at 0 until next frame.
                        if (row_q == 3'(NUM_REGS - 1)) begin
                            state_q <= V_IDLE;
                            row_q   <= '0;
                        end else begin
                            state_q <= V_ROW;
                            row_q   <= row_q + 3'd1;
                        end
                    end else begin
                        line_q <= line_q + 1'b1;
                    end
                end
                default: state_q <= V_IDLE;
            endcase
        end
    end

    assign row         = row_q;
    assign row_visible = (state_q == V_ROW);

endmodule

// File: rtl/vga_register_scheduler.sv
// Register panel renderer: per-frame snapshot, cell walker and 1-clk registered pixel.
module vga_register_scheduler
    import vga_overlay_pkg::*;
#(
    parameter int          NUM_REGS   = 7,
    parameter logic [10:0] START_H    = 11'd50,
    parameter logic [10:0] START_V    = 11'd10,
    parameter int          CELL_W     = 16,
    parameter int          ROW_H      = 20,
    parameter int          ROW_PITCH  = 30,
    parameter logic [2:0]  ON_COLOUR  = GREEN,
    parameter logic [2:0]  OFF_COLOUR = RED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] vga_h,
    input  logic [10:0] vga_v,
    input  logic [63:0] regs_in,
    input  logic        freeze,
    output logic [2:0]  pixel_out,
    output logic        display_on,
    output logic [2:0]  row_sel
);
    localparam int PW = $clog2(CELL_W);

    logic [7:0][7:0] snap_q;
    logic [2:0]      row;
    logic            row_visible;

    logic            act_q, act_d, cur_act;
    logic [2:0]      cell_q, cell_d, cur_cell;
    logic [PW-1:0]   px_q, px_d, cur_px;
    logic [2:0]      pix_d, pixel_q, row_sel_q;
    logic            on_q;

    vga_row_timer #(
        .NUM_REGS (NUM_REGS),
        .START_V  (START_V),
        .ROW_H    (ROW_H),
        .ROW_PITCH(ROW_PITCH)
    ) u_row_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .vga_h      (vga_h),
        .vga_v      (vga_v),
        .row        (row),
        .row_visible(row_visible)
    );

    // The START_H pixel itself is drawn, so arming is resolved combinationally.
    always_comb begin
        cur_act  = act_q;
        cur_cell = cell_q;
        cur_px   = px_q;
        if (row_visible && vga_h == START_H) begin
            cur_act  = 1'b1;
            cur_cell = '0;
            cur_px   = '0;
        end
        if (!row_visible) cur_act = 1'b0;

        act_d  = cur_act;
        cell_d = cur_cell;
        px_d   = cur_px + 1'b1;
        if (cur_px == PW'(CELL_W - 1)) begin
            px_d   = '0;
            cell_d = cur_cell + 3'd1;
            if (cur_cell == 3'd7) act_d = 1'b0;
        end
        if (!cur_act) begin
            act_d  = 1'b0;
            cell_d = '0;
            px_d   = '0;
        end

        pix_d = BLACK;
        if (cur_act && cur_px != PW'(CELL_W - 1))
            pix_d = snap_q[row][3'd7 - cur_cell] ? ON_COLOUR : OFF_COLOUR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q    <= '0;
            act_q     <= 1'b0;
            cell_q    <= '0;
            px_q      <= '0;
            pixel_q   <= BLACK;
            on_q      <= 1'b0;
            row_sel_q <= '0;
        end else begin
            if (vga_h == '0 && vga_v == '0 && !freeze) snap_q <= regs_in;
            act_q     <= act_d;
            cell_q    <= cell_d;
            px_q      <= px_d;
            pixel_q   <= pix_d;
            on_q      <= cur_act;
            row_sel_q <= row_visible ? row : 3'd0;
        end
    end

    assign pixel_out  = pixel_q;
    assign display_on = on_q;
    assign row_sel    = row_sel_q;

endmodule
